// File: rtl/terminal_text_controller_pkg.sv
// Shared definitions for the terminal text controller: default geometry,
// ASCII control codes and the controller state encoding.
package terminal_text_controller_pkg;

    localparam int DEF_COLS         = 80;
    localparam int DEF_ROWS         = 60;
    localparam int DEF_ADDR_W       = 13;
    localparam int DEF_BLINK_FRAMES = 30;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_SCROLL,
        ST_SCROLL_BLANK,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/terminal_text_controller_cursor_blink_timer.sv
// Cursor blink phase: counts falling edges of vertical sync and toggles the
// cursor visibility every BLINK_FRAMES frames; typing restarts a visible phase.
module terminal_text_controller_cursor_blink_timer
    import terminal_text_controller_pkg::*;
#(
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    input  logic restart,
    output logic cursor_on
);

    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic          vs_q;
    logic          vs_fall;
    logic [CW-1:0] frame_count;

    // vs is active low, so a frame starts on its 1->0 transition
    assign vs_fall = vs_q & ~vs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b1;
            frame_count <= '0;
            cursor_on   <= 1'b1;
        end else begin
            vs_q <= vs;
            if (restart) begin
                frame_count <= '0;
                cursor_on   <= 1'b1;
            end else if (vs_fall) begin
                if (frame_count == CW'(BLINK_FRAMES - 1)) begin
                    frame_count <= '0;
                    cursor_on   <= ~cursor_on;
                end else begin
                    frame_count <= frame_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/terminal_text_controller.sv
// Terminal text controller: owns the cursor and sequences every write into the
// character buffer (print, newline, backspace, wrap, scroll-up, clear-screen).
module terminal_text_controller
    import terminal_text_controller_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    input  logic              iKEY_VALID,
    input  logic [7:0]        iKEY_ASCII,
    output logic              oKEY_READY,
    input  logic              iCLEAR,
    input  logic              iVS,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [7:0]        oWR_DATA,
    output logic [ADDR_W-1:0] oRD_ADDR,
    input  logic [7:0]        iRD_DATA,
    output logic [6:0]        oCURSOR_COL,
    output logic [5:0]        oCURSOR_ROW,
    output logic              oCURSOR_ON,
    output logic              oBUSY
);

    localparam int                TOTAL         = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_COL_A    = ADDR_W'(COLS - 1);
    localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW      = 6'(ROWS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              rd_pend, rd_pend_n;
    logic [ADDR_W-1:0] pend_addr, pend_addr_n;
    logic              clear_pend, clear_n;
    logic [6:0]        col_n;
    logic [5:0]        row_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] wr_addr_n, rd_addr_n, cur_addr;
    logic [7:0]        wr_data_n;
    logic              ready_n, accept;

    assign cur_addr = ADDR_W'(oCURSOR_ROW) * COLS_A + ADDR_W'(oCURSOR_COL);

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            pend_addr   <= '0;
            clear_pend  <= 1'b0;
            oCURSOR_COL <= '0;
            oCURSOR_ROW <= '0;
            oWR_EN      <= 1'b0;
            oWR_ADDR    <= '0;
            oWR_DATA    <= '0;
            oRD_ADDR    <= '0;
            oKEY_READY  <= 1'b0;
            oBUSY       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rd_pend     <= rd_pend_n;
            pend_addr   <= pend_addr_n;
            clear_pend  <= clear_n;
            oCURSOR_COL <= col_n;
            oCURSOR_ROW <= row_n;
            oWR_EN      <= wr_en_n;
            oWR_ADDR    <= wr_addr_n;
            oWR_DATA    <= wr_data_n;
            oRD_ADDR    <= rd_addr_n;
            oKEY_READY  <= ready_n;
            oBUSY       <= (state_n != ST_IDLE);
        end
    end

    // Scroll is a two-stage stream: read address issued, data returns a cycle
    // later and is written one row up, so a read in flight always takes priority.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rd_pend_n   = 1'b0;
        pend_addr_n = pend_addr;
        clear_n     = clear_pend | iCLEAR;
        col_n       = oCURSOR_COL;
        row_n       = oCURSOR_ROW;
        wr_en_n     = 1'b0;
        wr_addr_n   = oWR_ADDR;
        wr_data_n   = oWR_DATA;
        rd_addr_n   = oRD_ADDR;
        accept      = 1'b0;

        if (rd_pend) begin
            wr_en_n   = 1'b1;
            wr_addr_n = pend_addr;
            wr_data_n = iRD_DATA;
        end

        case (state)
            ST_IDLE: begin
                if (clear_n) begin
                    state_n = ST_CLEAR;
                    cnt_n   = '0;
                    col_n   = '0;
                    row_n   = '0;
                    clear_n = 1'b0;
                end else if (iKEY_VALID && oKEY_READY) begin
                    accept = 1'b1;
                    if (iKEY_ASCII >= ASCII_SPACE && iKEY_ASCII <= ASCII_TILDE) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = cur_addr;
                        wr_data_n = iKEY_ASCII;
                        state_n   = ST_PUT;
                        if (oCURSOR_COL != LAST_COL) begin
                            col_n = oCURSOR_COL + 7'd1;
                        end else begin
                            col_n = '0;
                            if (oCURSOR_ROW != LAST_ROW) begin
                                row_n = oCURSOR_ROW + 6'd1;
                            end else begin
                                state_n   = ST_SCROLL;
                                rd_addr_n = COLS_A;
                            end
                        end
                    end else if (iKEY_ASCII == ASCII_LF || iKEY_ASCII == ASCII_CR) begin
                        col_n = '0;
                        if (oCURSOR_ROW != LAST_ROW) begin
                            row_n = oCURSOR_ROW + 6'd1;
                        end else begin
                            state_n   = ST_SCROLL;
                            rd_addr_n = COLS_A;
                        end
                    end else if (iKEY_ASCII == ASCII_BS) begin
                        // row*COLS+col-1 is the previous cell in both the same-row and row-wrap cases
                        if (oCURSOR_COL != 7'd0 || oCURSOR_ROW != 6'd0) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = cur_addr - ADDR_W'(1);
                            wr_data_n = ASCII_SPACE;
                            state_n   = ST_PUT;
                            if (oCURSOR_COL != 7'd0) begin
                                col_n = oCURSOR_COL - 7'd1;
                            end else begin
                                col_n = LAST_COL;
                                row_n = oCURSOR_ROW - 6'd1;
                            end
                        end
                    end
                end
            end
            ST_PUT: begin
                state_n = ST_IDLE;
            end
            ST_SCROLL: begin
                rd_pend_n   = 1'b1;
                pend_addr_n = oRD_ADDR - COLS_A;
                if (oRD_ADDR == LAST_ADDR) begin
                    state_n = ST_SCROLL_BLANK;
                    cnt_n   = '0;
                end else begin
                    rd_addr_n = oRD_ADDR + ADDR_W'(1);
                end
            end
            ST_SCROLL_BLANK: begin
                if (!rd_pend) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = LAST_ROW_BASE + cnt;
                    wr_data_n = ASCII_SPACE;
                    if (cnt == LAST_COL_A) begin
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt + ADDR_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cnt;
                wr_data_n = ASCII_SPACE;
                if (cnt == LAST_ADDR) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        ready_n = (state_n == ST_IDLE) && !clear_n;
    end

    terminal_text_controller_cursor_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk       (iVGA_CLK),
        .rst       (iRST),
        .vs        (iVS),
        .restart   (accept),
        .cursor_on (oCURSOR_ON)
    );

endmodule

// File: tb/tb_terminal_text_controller.sv
// Scoreboard bench for terminal_text_controller: a cursor/buffer model queues
// every expected buffer write, and a monitor pops and compares each DUT write.
module tb_terminal_text_controller;
    import terminal_text_controller_pkg::*;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int ADDR_W = 13;
    localparam int TOTAL  = COLS * ROWS;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_valid;
    logic [7:0]        key_ascii;
    logic              key_ready;
    logic              clear;
    logic              vs;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [6:0]        cursor_col;
    logic [5:0]        cursor_row;
    logic              cursor_on;
    logic              busy;

    logic [7:0] ram       [0:(1<<ADDR_W)-1];
    logic [7:0] model_mem [0:(1<<ADDR_W)-1];
    wr_t        exp_q[$];
    wr_t        mon_e;
    int         m_col, m_row, m_blink_cnt;
    logic       m_on;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    terminal_text_controller #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLINK_FRAMES(30)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST        (rst),
        .iKEY_VALID  (key_valid),
        .iKEY_ASCII  (key_ascii),
        .oKEY_READY  (key_ready),
        .iCLEAR      (clear),
        .iVS         (vs),
        .oWR_EN      (wr_en),
        .oWR_ADDR    (wr_addr),
        .oWR_DATA    (wr_data),
        .oRD_ADDR    (rd_addr),
        .iRD_DATA    (rd_data),
        .oCURSOR_COL (cursor_col),
        .oCURSOR_ROW (cursor_row),
        .oCURSOR_ON  (cursor_on),
        .oBUSY       (busy)
    );

    // Character buffer: dual-port RAM with one-cycle registered read
    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        rd_data <= ram[rd_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_write", {11'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("write", {11'd0, wr_addr, wr_data}, {11'd0, mon_e.addr, mon_e.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input int addr, input logic [7:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        exp_q.push_back(w);
        model_mem[addr] = data;
    endtask

    task automatic push_scroll();
        for (int i = 0; i < TOTAL - COLS; i++) push_write(i, model_mem[i + COLS]);
        for (int i = 0; i < COLS; i++) push_write((ROWS - 1) * COLS + i, ASCII_SPACE);
    endtask

    task automatic model_key(input logic [7:0] c);
        m_on        = 1'b1;
        m_blink_cnt = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_write(m_row * COLS + m_col, c);
            if (m_col < COLS - 1) m_col++;
            else begin
                m_col = 0;
                if (m_row < ROWS - 1) m_row++;
                else push_scroll();
            end
        end else if (c == 8'h0A || c == 8'h0D) begin
            m_col = 0;
            if (m_row < ROWS - 1) m_row++;
            else push_scroll();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_write(m_row * COLS + m_col, ASCII_SPACE);
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                push_write(m_row * COLS + m_col, ASCII_SPACE);
            end
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] c);
        int n = 0;
        key_valid = 1'b1;
        key_ascii = c;
        while (!(key_ready && !clear)) begin
            step();
            n++;
            if (n > 20000) begin
                check_output("accept_timeout", 32'd0, 32'd1);
                key_valid = 1'b0;
                return;
            end
        end
        model_key(c);
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        for (int i = 0; i < TOTAL; i++) push_write(i, ASCII_SPACE);
        m_col = 0;
        m_row = 0;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy || exp_q.size() != 0) begin
            step();
            n++;
            if (n > 20000) begin
                check_output("idle_timeout", 32'd0, 32'd1);
                exp_q.delete();
                return;
            end
        end
    endtask

    task automatic check_cursor(input string tag);
        check_output({tag, "_col"}, 32'(cursor_col), 32'(m_col));
        check_output({tag, "_row"}, 32'(cursor_row), 32'(m_row));
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            step(); step();
            vs = 1'b1;
            step(); step();
            m_blink_cnt++;
            if (m_blink_cnt == 30) begin
                m_blink_cnt = 0;
                m_on        = ~m_on;
            end
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_ascii = 8'h00; clear = 1'b0; vs = 1'b1;
        m_col = 0; m_row = 0; m_on = 1'b1; m_blink_cnt = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = 8'h00;
        step(); step();
        check_output("rst_ready", 32'(key_ready), 32'd0);
        check_output("rst_wr_en", 32'(wr_en), 32'd0);
        check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_output("rst_wr_data", 32'(wr_data), 32'd0);
        check_output("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cursor_on", 32'(cursor_on), 32'd1);
        check_cursor("rst");
        rst = 1'b0;
        step();
        check_output("ready_after_rst", 32'(key_ready), 32'd1);

        // Print 'A' at origin; ready drops for exactly one cycle
        apply_stimulus(8'h41);
        check_output("ready_low_after_put", 32'(key_ready), 32'd0);
        step();
        check_output("ready_back", 32'(key_ready), 32'd1);
        wait_idle();
        check_cursor("after_A");

        // Clear and key in the same cycle: clear wins, key follows the clear
        key_valid = 1'b1;
        key_ascii = 8'h43;
        pulse_clear();
        apply_stimulus(8'h43);
        wait_idle();
        check_cursor("clear_then_key");

        // Ignored control code
        apply_stimulus(8'h01);
        wait_idle();
        check_cursor("ignored_code");

        // Row wrap from column 79 of row 5
        for (int i = 0; i < 5; i++) apply_stimulus(8'h0A);
        for (int i = 0; i < COLS - 1; i++) apply_stimulus(8'(8'h21 + (i % 90)));
        check_cursor("at_79_5");
        apply_stimulus(8'h5A);
        wait_idle();
        check_cursor("after_Z");

        // CR on the last row scrolls the whole screen
        for (int i = 0; i < 53; i++) apply_stimulus(8'h0A);
        check_cursor("at_0_59");
        apply_stimulus(8'h0D);
        wait_idle();
        check_cursor("after_scroll");

        // Print that wraps off the last row lands before the scroll
        for (int i = 0; i < COLS - 1; i++) apply_stimulus(8'(8'h30 + (i % 40)));
        apply_stimulus(8'h57);
        wait_idle();
        check_cursor("after_wrap_scroll");

        // Backspace across a row boundary, at origin, and within a row
        pulse_clear();
        wait_idle();
        for (int i = 0; i < 3; i++) apply_stimulus(8'h0A);
        apply_stimulus(8'h08);
        wait_idle();
        check_cursor("bs_row_wrap");
        pulse_clear();
        wait_idle();
        apply_stimulus(8'h08);
        wait_idle();
        check_cursor("bs_origin");
        apply_stimulus(8'h78);
        apply_stimulus(8'h08);
        wait_idle();
        check_cursor("bs_in_row");

        // Clear requested mid-scroll is serviced after the scroll, before any key
        for (int i = 0; i < ROWS; i++) apply_stimulus(8'h0A);
        repeat (100) step();
        pulse_clear();
        apply_stimulus(8'h42);
        wait_idle();
        check_cursor("clear_mid_scroll");

        // Cursor blink over VS falling edges, restarted by an accepted key
        vs_pulses(30);
        check_output("blink_off", 32'(cursor_on), 32'(m_on));
        vs_pulses(15);
        check_output("blink_hold", 32'(cursor_on), 32'(m_on));
        apply_stimulus(8'h01);
        check_output("blink_restart", 32'(cursor_on), 32'(m_on));
        vs_pulses(29);
        check_output("blink_29", 32'(cursor_on), 32'(m_on));
        vs_pulses(1);
        check_output("blink_30", 32'(cursor_on), 32'(m_on));

        // Reset in the middle of a clear stops writes immediately
        pulse_clear();
        repeat (50) step();
        rst = 1'b1;
        #1;
        check_output("midrst_wr_en", 32'(wr_en), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        m_col = 0; m_row = 0; m_on = 1'b1; m_blink_cnt = 0;
        step(); step();
        rst = 1'b0;
        step();
        check_output("midrst_ready", 32'(key_ready), 32'd1);
        check_output("midrst_on", 32'(cursor_on), 32'd1);
        check_cursor("midrst");
        repeat (20) step();
        apply_stimulus(8'h45);
        wait_idle();
        check_cursor("after_reset_key");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
